// File: rtl/vpu_pipe.sv
// vpu_pipe: two-stage vector post-processing (bias add, ReLU / leaky-ReLU).
// Define VPU_PIPE_SAT_EN to clamp on every narrowing instead of wrapping.
module vpu_pipe #(
   parameter int DATA_W = 16,
   parameter int SIZE   = 8,
   parameter int DBITS  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_mode,
   input  logic                     in_last,
   input  logic [SIZE-1:0]          in_lane_en,
   input  logic [SIZE*DATA_W-1:0]   in_data,
   input  logic [SIZE*DATA_W-1:0]   bias_in,
   input  logic [DATA_W-1:0]        leak_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic [SIZE-1:0]          out_lane_en,
   output logic [SIZE*DATA_W-1:0]   out_data,
   output logic [SIZE-1:0]          out_sat,
   output logic                     idle
);

   localparam int PW = 2 * DATA_W;
   localparam logic signed [PW-1:0] MAXP =
      {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PW-1:0] MINP =
      {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic signed [PW-1:0] RND =
      {{(PW-1){1'b0}}, 1'b1} << (DBITS - 1);

   // Returns {clamped, value}.
   function automatic logic [DATA_W:0] f_narrow(
      input logic signed [PW-1:0] v
   );
`ifdef VPU_PIPE_SAT_EN
      if (v > MAXP)
         f_narrow = {1'b1, MAXP[DATA_W-1:0]};
      else if (v < MINP)
         f_narrow = {1'b1, MINP[DATA_W-1:0]};
      else
         f_narrow = {1'b0, v[DATA_W-1:0]};
`else
      f_narrow = {1'b0, v[DATA_W-1:0]};
`endif
   endfunction

   function automatic logic [DATA_W:0] f_bias(
      input logic signed [DATA_W-1:0] x,
      input logic signed [DATA_W-1:0] b,
      input logic                     sel
   );
      logic signed [DATA_W:0] s;
      s = {x[DATA_W-1], x} + {b[DATA_W-1], b};
      if (sel)
         f_bias = f_narrow({{(DATA_W-1){s[DATA_W]}}, s});
      else
         f_bias = {1'b0, x};
   endfunction

   function automatic logic [DATA_W:0] f_act(
      input logic signed [DATA_W-1:0] t,
      input logic signed [DATA_W-1:0] lk,
      input logic                     lsel,
      input logic                     rsel
   );
      logic signed [PW-1:0] p;
      p = (PW'(t) * PW'(lk) + RND) >>> DBITS;
      f_act = {1'b0, t};
      if (t[DATA_W-1]) begin
         if (lsel)
            f_act = f_narrow(p);
         else if (rsel)
            f_act = '0;
      end
   endfunction

   logic                   w_s1_adv;
   logic                   w_s2_adv;
   logic                   w_bsel;
   logic                   w_lsel;
   logic                   w_rsel;
   logic [SIZE*DATA_W-1:0] w_s1_t;
   logic [SIZE-1:0]        w_s1_sat;
   logic [SIZE*DATA_W-1:0] w_s2_d;
   logic [SIZE-1:0]        w_s2_sat;

   logic                   r_s1_v;
   logic [SIZE*DATA_W-1:0] r_s1_t;
   logic [SIZE-1:0]        r_s1_sat;
   logic                   r_s1_lsel;
   logic                   r_s1_rsel;
   logic                   r_s1_last;
   logic [SIZE-1:0]        r_s1_mask;
   logic [DATA_W-1:0]      r_s1_leak;

   logic                   r_out_v;
   logic                   r_out_last;
   logic [SIZE-1:0]        r_out_mask;
   logic [SIZE*DATA_W-1:0] r_out_d;
   logic [SIZE-1:0]        r_out_sat;

   assign w_s2_adv = !r_out_v || out_ready;
   assign w_s1_adv = !r_s1_v || w_s2_adv;
   assign in_ready = w_s1_adv && !rst;
   assign idle     = !r_s1_v && !r_out_v;

   always_comb begin
      w_bsel = 1'b0;
      w_lsel = 1'b0;
      w_rsel = 1'b0;
      unique case (in_mode)
         3'b001: w_bsel = 1'b1;
         3'b010: w_lsel = 1'b1;
         3'b011: begin
            w_bsel = 1'b1;
            w_lsel = 1'b1;
         end
         3'b100: w_rsel = 1'b1;
         3'b101: begin
            w_bsel = 1'b1;
            w_rsel = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_s1_t   = '0;
      w_s1_sat = '0;
      for (int i = 0; i < SIZE; i++) begin
         {w_s1_sat[i], w_s1_t[i*DATA_W +: DATA_W]} =
            f_bias(in_data[i*DATA_W +: DATA_W],
                   bias_in[i*DATA_W +: DATA_W], w_bsel);
      end
   end

   // Masked lanes are forced to zero with no saturation flag.
   always_comb begin
      w_s2_d   = '0;
      w_s2_sat = '0;
      for (int i = 0; i < SIZE; i++) begin
         logic [DATA_W:0] a;
         a = f_act(r_s1_t[i*DATA_W +: DATA_W], r_s1_leak,
                   r_s1_lsel, r_s1_rsel);
         if (r_s1_mask[i]) begin
            w_s2_d[i*DATA_W +: DATA_W] = a[DATA_W-1:0];
            w_s2_sat[i] = a[DATA_W] | r_s1_sat[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v     <= 1'b0;
         r_s1_t     <= '0;
         r_s1_sat   <= '0;
         r_s1_lsel  <= 1'b0;
         r_s1_rsel  <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_mask  <= '0;
         r_s1_leak  <= '0;
         r_out_v    <= 1'b0;
         r_out_last <= 1'b0;
         r_out_mask <= '0;
         r_out_d    <= '0;
         r_out_sat  <= '0;
      end else begin
         if (w_s1_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
               r_s1_t    <= w_s1_t;
               r_s1_sat  <= w_s1_sat;
               r_s1_lsel <= w_lsel;
               r_s1_rsel <= w_rsel;
               r_s1_last <= in_last;
               r_s1_mask <= in_lane_en;
               r_s1_leak <= leak_in;
            end
         end
         if (w_s2_adv) begin
            r_out_v <= r_s1_v;
            if (r_s1_v) begin
               r_out_last <= r_s1_last;
               r_out_mask <= r_s1_mask;
               r_out_d    <= w_s2_d;
               r_out_sat  <= w_s2_sat;
            end
         end
      end
   end

   assign out_valid   = r_out_v;
   assign out_last    = r_out_last;
   assign out_lane_en = r_out_mask;
   assign out_data    = r_out_d;
   assign out_sat     = r_out_sat;

endmodule

// File: doc/vpu_pipe.md
Name: vpu_pipe

Overview:
- Next-generation vector post-processing unit between systolic-array output and the unified buffer (UB).
- Applies a per-beat selectable op chain to SIZE lanes: bias add, then activation (none / ReLU / leaky-ReLU).
- Two pipeline stages with a valid/ready handshake and back-pressure. Mode travels with each beat, so modes switch cleanly between beats.
- Adds saturation, rounding, a lane mask and last-beat tagging.

Parameters:
- DATA_W, 16, lane data width (signed, Q(DATA_W-DBITS).DBITS)
- SIZE, 8, number of lanes
- DBITS, 8, fractional bits of leak factor; must be >= 1 and < DATA_W

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  beat offered
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_mode  input  3  op select for this beat
- in_last  input  1  last beat of vector, passed through
- in_lane_en  input  SIZE  per-lane enable
- in_data  input  SIZE x DATA_W  signed lane data
- bias_in  input  SIZE x DATA_W  signed per-lane bias, sampled with beat
- leak_in  input  DATA_W  signed leak factor, sampled with beat
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts
- out_last  output  1  tag of beat
- out_lane_en  output  SIZE  mask of beat
- out_data  output  SIZE x DATA_W  results
- out_sat  output  SIZE  per-lane saturation occurred on this beat
- idle  output  1  both stages empty

Behaviour:
- Reset: in_ready=0 while rst is high; all valid bits, out_data, out_last, out_lane_en and out_sat are 0; idle=1. An asserted rst mid-operation discards in-flight beats.
- Stage control:
  - s2_adv = !s2_v || out_ready
  - s1_adv = !s1_v || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid)
- Stage 1 registers the bias sum and the beat side-band (mode, last, mask, leak). Stage 2 registers the activation result onto the out_* ports.
- Latency: 2 cycles from accept to out_valid. Throughput: 1 beat/cycle with out_ready high.
- While out_valid && !out_ready, every out_* signal holds stable.
- in_mode values:
  - 000 pass
  - 001 bias
  - 010 leaky
  - 011 bias+leaky
  - 100 relu
  - 101 bias+relu
  - 110/111 treated as pass
- Bias: computed at DATA_W+1 bits, then narrowed to DATA_W (saturate or wrap, per Optional Feature). When bias is not selected, t = in_data.
- Leaky: if t >= 0, result = t. Otherwise:
  - p = t*leak at 2*DATA_W bits
  - p = p + (1 << (DBITS-1)) (round half up)
  - result = p >>> DBITS, narrowed to DATA_W
- ReLU: t < 0 gives 0.
- Lanes with lane_en=0 output 0 and out_sat=0; the mask is passed through unchanged.
- in_last and the mask travel with their beat; they are never merged or reordered.
- idle = !s1_v && !s2_v.

Optional Feature:
- Macro VPU_PIPE_SAT_EN.
- Defined: every narrowing clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1], and out_sat[i]=1 on the beat where a clamp occurred in lane i.
- Undefined: narrowing truncates (two's-complement wrap, legacy behaviour) and out_sat is constant 0.

Test Plan (DATA_W=16, DBITS=8):
- Reset/pipeline: assert rst mid-stream with 2 beats in flight -> out_valid=0, idle=1, in_ready=0 during rst. After release, mode 001, x=100, bias=-30 -> out_data=70 exactly 2 cycles after accept, in_ready=1 throughout.
- Leaky rounding: mode 010, leak=32:
  - x=-256 -> -32
  - x=-3 -> 0 (rounding)
  - x=500 -> 500
- Bias+activation: mode 011, x=-512, bias=256, leak=32 -> -32. Mode 101, x=-5, bias=2 -> 0. Mode 111, x=-7 -> -7.
- Saturation: mode 001, x=32000, bias=1000:
  - with VPU_PIPE_SAT_EN -> 32767, out_sat=1
  - without -> -32536, out_sat=0
- Back-pressure: hold out_ready=0, offer beats A,B,C back-to-back -> A and B accepted, in_ready=0 while C is offered, out_data=A held stable. Release out_ready -> A, B, C emitted on consecutive cycles, out_last only on the beat sent with in_last=1.
- Lane mask: in_lane_en=8'b1010_0101, all x=10, mode 000 -> lanes 0,2,5,7 output 10, others 0, out_lane_en matches.
